tlb_op_ctrl: RTL and testbench

- Sequencer for LoongArch32 TLB-maintenance instructions: TLBSRCH, TLBRD, TLBWR, TLBFILL, INVTLB.
- Accepts one op at a time from the commit stage over a valid/ready handshake.
- Drives the TLB array read/write/invalidate ports and produces the CSR update strobes: TLBRD_en and VPN to TLBEHI, index/NE to TLBIDX.
- Multi-cycle INVTLB walk runs here, so the pipeline stalls on op_ready instead of sequencing the array itself.

---
 rtl/tlb_op_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_tlb_op_ctrl.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tlb_op_ctrl.sv
// Sequencer for LoongArch32 TLB maintenance ops (TLBSRCH/TLBRD/TLBWR/TLBFILL/INVTLB).
// Optional build macro TLB_OP_PERF_CNT_EN adds inv_cnt/op_cnt performance counters.
module tlb_op_ctrl #(
  parameter int unsigned TLBNUM = 16,
  parameter int unsigned IDX_W  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             op_vld,
  output logic             op_ready,
  input  logic [2:0]       op_code,
  input  logic [4:0]       inv_op,
  input  logic [9:0]       inv_asid,
  input  logic [18:0]      inv_va,
  input  logic [IDX_W-1:0] csr_index,
  input  logic             srch_hit,
  input  logic [IDX_W-1:0] srch_idx,
  output logic [IDX_W-1:0] tlb_rd_idx,
  input  logic             tlb_rd_e,
  input  logic             tlb_rd_g,
  input  logic [9:0]       tlb_rd_asid,
  input  logic [18:0]      tlb_rd_vppn,
  output logic             tlb_we,
  output logic [IDX_W-1:0] tlb_wr_idx,
  output logic             tlb_inv_en,
  output logic [IDX_W-1:0] tlb_inv_idx,
  output logic             TLBRD_en,
  output logic [18:0]      TLB_VPN_RD,
  output logic             tlbidx_we,
  output logic             tlbidx_ne,
  output logic [IDX_W-1:0] tlbidx_index,
  output logic             op_done,
  output logic             op_ine
`ifdef TLB_OP_PERF_CNT_EN
  ,
  output logic [31:0]      inv_cnt,
  output logic [31:0]      op_cnt
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SRCH,
    S_RD,
    S_WR,
    S_INV,
    S_DONE
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TLBNUM - 1);

  state_t           state;
  logic [IDX_W-1:0] fill_cnt;
  logic [IDX_W-1:0] walk_idx;
  logic [IDX_W-1:0] csr_idx_q;
  logic [IDX_W-1:0] wr_idx_q;
  logic [4:0]       inv_op_q;
  logic [9:0]       inv_asid_q;
  logic [18:0]      inv_va_q;
  logic             ine_q;

  logic             illegal_op;
  logic             inv_match;
  logic             asid_eq;
  logic             va_eq;

  assign illegal_op = (op_code > 3'd4) || ((op_code == 3'd4) && (inv_op > 5'd6));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      fill_cnt   <= '0;
      walk_idx   <= '0;
      csr_idx_q  <= '0;
      wr_idx_q   <= '0;
      inv_op_q   <= '0;
      inv_asid_q <= '0;
      inv_va_q   <= '0;
      ine_q      <= 1'b0;
    end else begin
      fill_cnt <= (fill_cnt == LAST_IDX) ? '0 : fill_cnt + 1'b1;
      case (state)
        S_IDLE: begin
          if (op_vld) begin
            csr_idx_q  <= csr_index;
            inv_op_q   <= inv_op;
            inv_asid_q <= inv_asid;
            inv_va_q   <= inv_va;
            walk_idx   <= '0;
            wr_idx_q   <= (op_code == 3'd2) ? csr_index : fill_cnt;
            ine_q      <= illegal_op;
            if (illegal_op) begin
              state <= S_DONE;
            end else begin
              case (op_code)
                3'd0:    state <= S_SRCH;
                3'd1:    state <= S_RD;
                3'd2,
                3'd3:    state <= S_WR;
                default: state <= S_INV;
              endcase
            end
          end
        end
        S_SRCH, S_RD, S_WR: state <= S_DONE;
        S_INV: begin
          if (walk_idx == LAST_IDX) begin
            state <= S_DONE;
          end else begin
            walk_idx <= walk_idx + 1'b1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          ine_q <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign asid_eq = (tlb_rd_asid == inv_asid_q);
  assign va_eq   = (tlb_rd_vppn == inv_va_q);

  always_comb begin
    inv_match = 1'b0;
    case (inv_op_q)
      5'd0, 5'd1: inv_match = 1'b1;
      5'd2:       inv_match = tlb_rd_g;
      5'd3:       inv_match = ~tlb_rd_g;
      5'd4:       inv_match = ~tlb_rd_g & asid_eq;
      5'd5:       inv_match = ~tlb_rd_g & asid_eq & va_eq;
      5'd6:       inv_match = (tlb_rd_g | asid_eq) & va_eq;
      default:    inv_match = 1'b0;
    endcase
  end

  // Outputs decode the registered state; the search and array-read results arrive
  // combinationally in the same cycle, so the data-dependent strobes cannot be flopped.
  always_comb begin
    op_ready     = 1'b0;
    tlb_rd_idx   = '0;
    tlb_we       = 1'b0;
    tlb_wr_idx   = '0;
    tlb_inv_en   = 1'b0;
    tlb_inv_idx  = '0;
    TLBRD_en     = 1'b0;
    TLB_VPN_RD   = '0;
    tlbidx_we    = 1'b0;
    tlbidx_ne    = 1'b0;
    tlbidx_index = '0;
    op_done      = 1'b0;
    op_ine       = 1'b0;
    case (state)
      S_IDLE: op_ready = 1'b1;
      S_SRCH: begin
        tlbidx_we    = 1'b1;
        tlbidx_ne    = ~srch_hit;
        tlbidx_index = srch_hit ? srch_idx : csr_idx_q;
      end
      S_RD: begin
        tlb_rd_idx   = csr_idx_q;
        tlbidx_we    = 1'b1;
        tlbidx_ne    = ~tlb_rd_e;
        tlbidx_index = csr_idx_q;
        TLBRD_en     = tlb_rd_e;
        TLB_VPN_RD   = tlb_rd_vppn;
      end
      S_WR: begin
        tlb_we     = 1'b1;
        tlb_wr_idx = wr_idx_q;
      end
      S_INV: begin
        tlb_rd_idx  = walk_idx;
        tlb_inv_idx = walk_idx;
        tlb_inv_en  = inv_match;
      end
      S_DONE: begin
        op_done = 1'b1;
        op_ine  = ine_q;
      end
      default: ;
    endcase
  end

`ifdef TLB_OP_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inv_cnt <= '0;
      op_cnt  <= '0;
    end else begin
      inv_cnt <= inv_cnt + {31'd0, tlb_inv_en};
      op_cnt  <= op_cnt + {31'd0, op_done};
    end
  end
`endif

endmodule

// File: tb/tb_tlb_op_ctrl.sv
// Directed self-checking bench for tlb_op_ctrl with a small TLB array model.
module tb_tlb_op_ctrl;
  localparam int unsigned TLBNUM = 16;
  localparam int unsigned IDX_W  = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             op_vld = 1'b0;
  logic             op_ready;
  logic [2:0]       op_code = '0;
  logic [4:0]       inv_op = '0;
  logic [9:0]       inv_asid = '0;
  logic [18:0]      inv_va = '0;
  logic [IDX_W-1:0] csr_index = '0;
  logic             srch_hit = 1'b0;
  logic [IDX_W-1:0] srch_idx = '0;
  logic [IDX_W-1:0] tlb_rd_idx;
  logic             tlb_rd_e;
  logic             tlb_rd_g;
  logic [9:0]       tlb_rd_asid;
  logic [18:0]      tlb_rd_vppn;
  logic             tlb_we;
  logic [IDX_W-1:0] tlb_wr_idx;
  logic             tlb_inv_en;
  logic [IDX_W-1:0] tlb_inv_idx;
  logic             TLBRD_en;
  logic [18:0]      TLB_VPN_RD;
  logic             tlbidx_we;
  logic             tlbidx_ne;
  logic [IDX_W-1:0] tlbidx_index;
  logic             op_done;
  logic             op_ine;
`ifdef TLB_OP_PERF_CNT_EN
  logic [31:0]      inv_cnt;
  logic [31:0]      op_cnt;
`endif

  logic             e_m    [TLBNUM];
  logic             g_m    [TLBNUM];
  logic [9:0]       asid_m [TLBNUM];
  logic [18:0]      vppn_m [TLBNUM];
  logic [IDX_W-1:0] fill_model;

  int unsigned errors = 0;
  int unsigned checks = 0;

  always #5 clk = ~clk;

  assign tlb_rd_e    = e_m[tlb_rd_idx];
  assign tlb_rd_g    = g_m[tlb_rd_idx];
  assign tlb_rd_asid = asid_m[tlb_rd_idx];
  assign tlb_rd_vppn = vppn_m[tlb_rd_idx];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) fill_model <= '0;
    else        fill_model <= fill_model + 1'b1;
  end

  tlb_op_ctrl #(.TLBNUM(TLBNUM), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst_n(rst_n), .op_vld(op_vld), .op_ready(op_ready),
    .op_code(op_code), .inv_op(inv_op), .inv_asid(inv_asid), .inv_va(inv_va),
    .csr_index(csr_index), .srch_hit(srch_hit), .srch_idx(srch_idx),
    .tlb_rd_idx(tlb_rd_idx), .tlb_rd_e(tlb_rd_e), .tlb_rd_g(tlb_rd_g),
    .tlb_rd_asid(tlb_rd_asid), .tlb_rd_vppn(tlb_rd_vppn),
    .tlb_we(tlb_we), .tlb_wr_idx(tlb_wr_idx),
    .tlb_inv_en(tlb_inv_en), .tlb_inv_idx(tlb_inv_idx),
    .TLBRD_en(TLBRD_en), .TLB_VPN_RD(TLB_VPN_RD),
    .tlbidx_we(tlbidx_we), .tlbidx_ne(tlbidx_ne), .tlbidx_index(tlbidx_index),
    .op_done(op_done), .op_ine(op_ine)
`ifdef TLB_OP_PERF_CNT_EN
    , .inv_cnt(inv_cnt), .op_cnt(op_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Presents an op at a negedge; the following posedge accepts it, and the
  // task returns at the negedge of the first post-accept cycle.
  task automatic issue(input logic [2:0] code, input logic [IDX_W-1:0] idx);
    op_vld    = 1'b1;
    op_code   = code;
    csr_index = idx;
    @(negedge clk);
    op_vld    = 1'b0;
  endtask

  initial begin
    int unsigned n;
    int unsigned inv_hits;
    logic [IDX_W-1:0] hit_idx;
    logic ready_seen;
    logic done_seen;

    for (int i = 0; i < TLBNUM; i++) begin
      e_m[i] = 1'b1; g_m[i] = 1'b0; asid_m[i] = '0; vppn_m[i] = '0;
    end
    repeat (3) @(negedge clk);
    chk("rst_op_ready", op_ready, 1);
    chk("rst_tlb_we", tlb_we, 0);
    chk("rst_inv_en", tlb_inv_en, 0);
    chk("rst_tlbidx_we", tlbidx_we, 0);
    chk("rst_op_done", op_done, 0);
    chk("rst_rd_idx", tlb_rd_idx, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // TLBRD of a valid entry
    vppn_m[5] = 19'h1ABCD;
    e_m[5]    = 1'b1;
    issue(3'd1, 4'd5);
    chk("rd_rd_idx", tlb_rd_idx, 5);
    chk("rd_TLBRD_en", TLBRD_en, 1);
    chk("rd_vpn", TLB_VPN_RD, 19'h1ABCD);
    chk("rd_tlbidx_we", tlbidx_we, 1);
    chk("rd_ne", tlbidx_ne, 0);
    chk("rd_index", tlbidx_index, 5);
    chk("rd_busy", op_ready, 0);
    @(negedge clk);
    chk("rd_done", op_done, 1);
    chk("rd_ine", op_ine, 0);
    chk("rd_done_ready", op_ready, 0);
    @(negedge clk);
    chk("rd_ready_back", op_ready, 1);

    // TLBRD of an invalid entry
    e_m[5] = 1'b0;
    issue(3'd1, 4'd5);
    chk("rd0_TLBRD_en", TLBRD_en, 0);
    chk("rd0_ne", tlbidx_ne, 1);
    chk("rd0_tlbidx_we", tlbidx_we, 1);
    repeat (2) @(negedge clk);
    e_m[5] = 1'b1;

    // TLBSRCH hit then miss
    srch_hit = 1'b1; srch_idx = 4'd9;
    issue(3'd0, 4'd3);
    chk("srch_hit_we", tlbidx_we, 1);
    chk("srch_hit_index", tlbidx_index, 9);
    chk("srch_hit_ne", tlbidx_ne, 0);
    repeat (2) @(negedge clk);
    srch_hit = 1'b0;
    issue(3'd0, 4'd3);
    chk("srch_miss_index", tlbidx_index, 3);
    chk("srch_miss_ne", tlbidx_ne, 1);
    repeat (2) @(negedge clk);

    // TLBWR uses csr_index
    issue(3'd2, 4'd11);
    chk("wr_we", tlb_we, 1);
    chk("wr_idx", tlb_wr_idx, 11);
    chk("wr_no_tlbidx", tlbidx_we, 0);
    repeat (2) @(negedge clk);

    // TLBFILL at fill_cnt==14, then back-to-back FILL after the wrap
    n = 0;
    while (fill_model != 4'd14 && n < 40) begin
      @(negedge clk); n++;
    end
    chk("fill_wait", (n < 40), 1);
    chk("fill_ready", op_ready, 1);
    issue(3'd3, 4'd7);
    chk("fill_we", tlb_we, 1);
    chk("fill_idx14", tlb_wr_idx, 14);
    @(negedge clk);
    @(negedge clk);
    issue(3'd3, 4'd7);
    chk("fill_idx_wrap", tlb_wr_idx, 1);
    repeat (2) @(negedge clk);

    // INVTLB op5: only entry 2 matches (entry 7 is global, entry 3 has a different VA)
    g_m[2] = 1'b0; asid_m[2] = 10'h12; vppn_m[2] = 19'h00400;
    g_m[7] = 1'b1; asid_m[7] = 10'h12; vppn_m[7] = 19'h00400;
    g_m[3] = 1'b0; asid_m[3] = 10'h12; vppn_m[3] = 19'h00401;
    inv_op = 5'd5; inv_asid = 10'h12; inv_va = 19'h00400;
    issue(3'd4, 4'd0);
    n = 1; inv_hits = 0; hit_idx = '0; ready_seen = 1'b0; done_seen = 1'b0;
    while (!done_seen && n < 40) begin
      if (op_done) done_seen = 1'b1;
      else begin
        if (op_ready) ready_seen = 1'b1;
        if (tlb_inv_en) begin inv_hits++; hit_idx = tlb_inv_idx; end
        @(negedge clk); n++;
      end
    end
    chk("inv5_done_seen", done_seen, 1);
    // cycles counted from the accept cycle through the done cycle, inclusive
    chk("inv5_latency", n + 1, TLBNUM + 2);
    chk("inv5_hits", inv_hits, 1);
    chk("inv5_hit_idx", hit_idx, 2);
    chk("inv5_ready_low", ready_seen, 0);
    chk("inv5_ine", op_ine, 0);
    @(negedge clk);

    // Illegal inv_op and illegal op_code
    inv_op = 5'd7;
    issue(3'd4, 4'd0);
    chk("inv7_done", op_done, 1);
    chk("inv7_ine", op_ine, 1);
    chk("inv7_side", {tlb_we, tlb_inv_en, tlbidx_we}, 0);
    @(negedge clk);
    chk("inv7_ready", op_ready, 1);
    issue(3'd6, 4'd0);
    chk("op6_done", op_done, 1);
    chk("op6_ine", op_ine, 1);
    chk("op6_side", {tlb_we, tlb_inv_en, tlbidx_we}, 0);
    @(negedge clk);

    // Reset during an INVTLB op0 walk at walk_idx 6
    inv_op = 5'd0;
    issue(3'd4, 4'd0);
    repeat (6) @(negedge clk);
    chk("midrst_idx6", tlb_inv_idx, 6);
    chk("midrst_en6", tlb_inv_en, 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_inv_en", tlb_inv_en, 0);
    chk("midrst_ready", op_ready, 1);
    chk("midrst_rd_idx", tlb_rd_idx, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    done_seen = 1'b0; inv_hits = 0; ready_seen = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (op_done) done_seen = 1'b1;
      if (tlb_inv_en) inv_hits++;
      if (!op_ready) ready_seen = 1'b0;
    end
    chk("midrst_no_done", done_seen, 0);
    chk("midrst_no_inv", inv_hits, 0);
    chk("midrst_ready_after", ready_seen, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
